// File: rtl/sq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sq_pkg
// Brief   : Shared types, default width and sizing helper for the squarer.
// Revision: 1.0 - initial release
// ============================================================================
package sq_pkg;

    localparam int SQ_N = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } sq_state_e;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sq_shift_add_step.sv
`default_nettype none
// ============================================================================
// Module  : sq_shift_add_step
// Brief   : One shift-add partial product: adds mcand into acc when bit is set.
// Revision: 1.0 - initial release
// ============================================================================
module sq_shift_add_step #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_acc,
    input  logic [N-1:0] i_mcand,
    input  logic         i_bit,
    output logic [N-1:0] o_acc
);

    assign o_acc = i_bit ? (i_acc + i_mcand) : i_acc;

endmodule
`default_nettype wire

// File: rtl/sq_square.sv
`default_nettype none
// ============================================================================
// Module  : sq_square
// Brief   : Sequential shift-add squarer, N/2-bit root in, exact N-bit square out.
// Revision: 1.0 - initial release
// ============================================================================
module sq_square
    import sq_pkg::*;
#(
    parameter int N = SQ_N
) (
    input  logic           Clock,
    input  logic           reset_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N/2-1:0] root_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   square_out,
    output logic           busy
);

    localparam int H  = N / 2;
    localparam int CW = clog2(H);
    localparam logic [CW-1:0] c_LAST = CW'(H - 1);

    sq_state_e     r_state;
    logic [N-1:0]  r_acc;
    logic [N-1:0]  r_mcand;
    logic [H-1:0]  r_mplier;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_square;
    logic [N-1:0]  w_acc_next;

    sq_shift_add_step #(
        .N (N)
    ) u_step (
        .i_acc   (r_acc),
        .i_mcand (r_mcand),
        .i_bit   (r_mplier[0]),
        .o_acc   (w_acc_next)
    );

    // Handshake flags decode straight from state so reset clears them at once.
    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == DONE);
    assign busy       = (r_state != IDLE);
    assign square_out = r_square;

    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_square <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mcand  <= {{(N - H){1'b0}}, root_in};
                        r_mplier <= root_in;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    // Counter parks on the last index rather than wrapping.
                    if (r_cnt == c_LAST) begin
                        r_square <= w_acc_next;
                        r_state  <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
